mem_write_checker: RTL

//  Self-checking monitor for the multi-cycle MIPS memory write bus (memwrite/dataadr/writedata).

---
 rtl/mem_write_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_write_checker.sv
// Ordered expected-write monitor for the MIPS memory write bus.
// Tracks a programmed table of writes and reports pass, fail or timeout.
module mem_write_checker #(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 4096,
    parameter  int STRICT  = 0,
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             exp_we,
    input  logic [IW-1:0]    exp_idx,
    input  logic [WIDTH-1:0] exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic [IW:0]      exp_count,
    input  logic             ignore_en,
    input  logic [WIDTH-1:0] ignore_addr,
    input  logic             start,
    input  logic             clear,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [IW:0]      match_count,
    output logic [WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0] fail_data,
    output logic [31:0]      cycles
);

    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DMAX = CW'(DEPTH);
    localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PASS,
        S_FAIL,
        S_TMO
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] tab_addr [DEPTH];
    logic [WIDTH-1:0] tab_data [DEPTH];
    logic [IW-1:0]    ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    cnt_in;

    logic ev;
    logic is_match;
    logic last;
    logic tmo_hit;

    always_comb begin
        ev       = memwrite && !(ignore_en && dataadr == ignore_addr);
        is_match = ev && dataadr == tab_addr[ptr]
                      && writedata == tab_data[ptr];
        last     = CW'(ptr) == count - 1'b1;
        tmo_hit  = (TIMEOUT != 0) && cycles == TLIM;
        // Zero means a single entry; oversize counts clamp to the table.
        if (exp_count == '0)
            cnt_in = CW'(1);
        else if (exp_count > DMAX)
            cnt_in = DMAX;
        else
            cnt_in = exp_count;
    end

    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:
                    if (start) state_n = S_ARMED;
                S_ARMED:
                    if (is_match && last)
                        state_n = S_PASS;
                    else if (ev && !is_match && STRICT != 0)
                        state_n = S_FAIL;
                    else if (tmo_hit)
                        state_n = S_TMO;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_addr[i] <= '0;
                tab_data[i] <= '0;
            end
            ptr         <= '0;
            count       <= '0;
            match_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            cycles      <= '0;
        end else if (clear) begin
            ptr         <= '0;
            count       <= '0;
            match_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            cycles      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (exp_we && 32'(exp_idx) < DEPTH) begin
                        tab_addr[exp_idx] <= exp_addr;
                        tab_data[exp_idx] <= exp_data;
                    end
                    if (start) begin
                        count       <= cnt_in;
                        ptr         <= '0;
                        cycles      <= '0;
                        match_count <= '0;
                    end
                end
                S_ARMED: begin
                    if (cycles != '1)
                        cycles <= cycles + 1'b1;
                    if (is_match) begin
                        ptr         <= ptr + 1'b1;
                        match_count <= match_count + 1'b1;
                    end else if (ev && STRICT != 0) begin
                        fail_addr <= dataadr;
                        fail_data <= writedata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = state == S_ARMED;
    assign pass    = state == S_PASS;
    assign fail    = state == S_FAIL;
    assign timeout = state == S_TMO;
    assign done    = pass || fail || timeout;

endmodule
